// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle multiply/divide unit for the RV M-extension operations
// (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at width XLEN.
//
// Division is a restoring divider producing one quotient bit per cycle.
// Multiplication is an iterative shift-add by default. When the macro
// MULDIV_FAST_MUL_EN is defined, multiplies instead use a single-cycle
// combinational product registered straight into the result.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  unit can accept (high only in IDLE)
//   op         in   funct3: 000 MUL 001 MULH 010 MULHSU 011 MULHU
//                           100 DIV 101 DIVU 110 REM 111 REMU
//   a, b       in   rs1 / rs2 operands
//   flush      in   synchronous abort of any in-flight or pending operation
//   out_valid  out  registered result available
//   out_ready  in   consumer takes the result
//   result     out  registered result
//   busy       out  high in CALC or DONE
//   dbg_state  out  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready depends only on the FSM state, never on in_valid.
// Once out_valid is high it stays high with result unchanged until the
// edge where out_ready is seen high, or until flush.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0]   ONE_X   = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X  = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Registered state
    state_t            state_q,     state_d;
    logic [2:0]        op_q,        op_d;
    logic              neg_q,       neg_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic [XLEN-1:0]   mcand_q,     mcand_d;
    logic [2*XLEN-1:0] acc_q,       acc_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q,    result_d;

    // Request decode
    logic              is_div;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              neg_res;
    logic              div_by_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;

    // Iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_sub;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step_acc;
    logic              last_step;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    // Apply the sign fix-up and pick the architectural result.
    // For multiplies the whole 2*XLEN product is negated before selection,
    // so the high half picks up the borrow from the low half correctly.
    // For divides acc holds {remainder, quotient}.
    function automatic logic [XLEN-1:0] fixup(input logic [2:0]        f_op,
                                              input logic [2*XLEN-1:0] f_acc,
                                              input logic              f_neg);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   val;
        if (f_op[2]) begin
            val = f_op[1] ? f_acc[2*XLEN-1:XLEN] : f_acc[XLEN-1:0];
            return f_neg ? ((~val) + ONE_X) : val;
        end else begin
            prod = f_neg ? ((~f_acc) + ONE_2X) : f_acc;
            return (f_op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    endfunction

    // ------------------------------------------------------------------
    // Request decode: signedness, magnitudes, result sign, special cases
    // ------------------------------------------------------------------
    always_comb begin
        is_div   = op[2];
        // a is signed for MULH, MULHSU, DIV, REM; b for MULH, DIV, REM
        a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        // The most-negative value maps onto itself, which is its correct
        // unsigned magnitude.
        a_mag    = a_neg ? ((~a) + ONE_X) : a;
        b_mag    = b_neg ? ((~b) + ONE_X) : b;

        // Remainder sign follows the dividend; everything else is the xor.
        if (is_div && op[1]) begin
            neg_res = a_neg;
        end else begin
            neg_res = a_neg ^ b_neg;
        end

        div_by_zero = (b == '0);
        div_ovf     = is_div && !op[0] && (a == MIN_NEG) && (b == '1);
        special     = is_div && (div_by_zero || div_ovf);

        if (div_by_zero) begin
            special_res = op[1] ? a : '1;
        end else begin
            special_res = op[1] ? '0 : a;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    end
`endif

    // ------------------------------------------------------------------
    // One iteration step
    //   multiply: acc = {partial_hi, multiplier}; add the multiplicand into
    //             the top half when the low bit is set, then shift right.
    //   divide:   acc = {remainder, dividend/quotient}; shift left one bit,
    //             subtract the divisor when it fits, shift in the q bit.
    // The remainder is carried one bit wider during the compare because
    // 2*rem+1 can exceed XLEN bits even though rem < divisor.
    // ------------------------------------------------------------------
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_ge   = (rem_sh >= {1'b0, mcand_q});
        rem_sub  = rem_sh - {1'b0, mcand_q};
        rem_new  = rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
        div_next = {rem_new, acc_q[XLEN-2:0], rem_ge};

        step_acc  = op_q[2] ? div_next : mul_next;
        last_step = (cnt_q == CW'(XLEN - 1));
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;

        if (flush) begin
            // Abort wins over accept, out_ready and the counter.
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d  = op;
                        neg_d = neg_res;
                        cnt_d = '0;
                        if (special) begin
                            result_d    = special_res;
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div) begin
                            result_d    = fixup(op, fast_prod, neg_res);
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end
`endif
                        else begin
                            state_d = S_CALC;
                            if (is_div) begin
                                mcand_d = b_mag;
                                acc_d   = {{XLEN{1'b0}}, a_mag};
                            end else begin
                                mcand_d = a_mag;
                                acc_d   = {{XLEN{1'b0}}, b_mag};
                            end
                        end
                    end
                end

                S_CALC: begin
                    acc_d = step_acc;
                    if (last_step) begin
                        // Final step and sign fix-up land on the same edge.
                        cnt_d       = '0;
                        result_d    = fixup(op_q, step_acc, neg_q);
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end

                default: begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 3'b000;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule
